// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches 16-bit words over a req/ack
// memory handshake and presents the decoded instruction with valid/ready.
module fetch_unit #(
  parameter int          PC_W    = 8,
  parameter logic [3:0]  HALT_OP = 4'b1111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_load_val,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [3:0]      opcode,
  output logic [3:0]      rd,
  output logic [3:0]      rs1,
  output logic [3:0]      rs2,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt;
  logic [15:0]     ir_p0, ir_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc_q  <= '0;
      ir_p0 <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      ir_p0 <= ir_nxt;
    end
  end

  // A jump overrides everything: a same-cycle ack or a pending transfer is dropped.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ir_nxt    = ir_p0;
    if (pc_load) begin
      pc_nxt    = pc_load_val;
      state_nxt = run ? S_FETCH : S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) state_nxt = S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir_nxt    = imem_rdata;
            pc_nxt    = pc_q + PC_W'(1);
            state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            if (ir_p0[15:12] == HALT_OP) state_nxt = S_HALT;
            else if (run)                state_nxt = S_FETCH;
            else                         state_nxt = S_IDLE;
          end
        end
        S_HALT: begin
          state_nxt = S_HALT;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Stage p0 boundary: decoded fields come straight from the instruction register.
  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = (state == S_HOLD);
  assign halted      = (state == S_HALT);
  assign opcode      = ir_p0[15:12];
  assign rd          = ir_p0[11:8];
  assign rs1         = ir_p0[7:4];
  assign rs2         = ir_p0[3:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a flag-level behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        pc_load = 1'b0;
  logic [7:0]  pc_load_val = 8'h00;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [3:0]  opcode, rd, rs1, rs2;
  logic [7:0]  pc;
  logic        halted;

  fetch_unit #(.PC_W(8), .HALT_OP(4'b1111)) dut (
    .clk(clk), .rst(rst), .run(run), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending fetch / held instruction / stopped flags.
  logic [7:0]  m_pc = 8'h00;
  logic [15:0] m_ir = 16'h0000;
  logic        m_fetching = 1'b0;
  logic        m_holding = 1'b0;
  logic        m_stopped = 1'b0;
  int          xfers = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 8'h00; m_ir <= 16'h0000;
      m_fetching <= 1'b0; m_holding <= 1'b0; m_stopped <= 1'b0;
    end else if (pc_load) begin
      m_pc <= pc_load_val; m_fetching <= run; m_holding <= 1'b0; m_stopped <= 1'b0;
    end else if (m_stopped) begin
      m_stopped <= 1'b1;
    end else if (m_holding) begin
      if (instr_ready) begin
        m_holding <= 1'b0;
        xfers <= xfers + 1;
        if (m_ir[15:12] == 4'hF) m_stopped <= 1'b1;
        else                     m_fetching <= run;
      end
    end else if (m_fetching) begin
      if (imem_ack) begin
        m_ir <= imem_rdata; m_pc <= m_pc + 8'd1;
        m_fetching <= 1'b0; m_holding <= 1'b1;
      end
    end else begin
      m_fetching <= run;
    end
  end

  // Compare process: every output, every cycle.
  always @(negedge clk) begin
    check("m_req",    32'(imem_req),    32'(m_fetching));
    check("m_addr",   32'(imem_addr),   32'(m_pc));
    check("m_pc",     32'(pc),          32'(m_pc));
    check("m_valid",  32'(instr_valid), 32'(m_holding));
    check("m_halted", 32'(halted),      32'(m_stopped));
    check("m_fields", 32'({opcode, rd, rs1, rs2}), 32'(m_ir));
  end

  // Memory responder: acks a request after lat waiting cycles.
  logic [15:0] mem [256];
  int lat = 0;
  int wcnt = 0;
  bit ovr = 1'b0;
  bit rnd_lat = 1'b0;

  task automatic drive_mem();
    if (ovr) return;
    if (imem_req) begin
      if (rnd_lat && wcnt == 0) lat = $urandom_range(0, 3);
      imem_rdata = mem[imem_addr];
      if (wcnt >= lat) begin
        imem_ack = 1'b1; wcnt = 0;
      end else begin
        imem_ack = 1'b0; wcnt++;
      end
    end else begin
      imem_ack = 1'b0; wcnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    drive_mem();
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; pc_load = 1'b0; instr_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    tick(); tick();

    // Zero-wait fetch of 16'h2123 at address 0.
    mem[0] = 16'h2123;
    rst = 1'b0; run = 1'b1; instr_ready = 1'b1; lat = 0;
    check("rst_req",    32'(imem_req),    32'h0);
    check("rst_valid",  32'(instr_valid), 32'h0);
    check("rst_pc",     32'(pc),          32'h0);
    check("rst_fields", 32'({opcode, rd, rs1, rs2}), 32'h0);
    tick();
    check("a_req1",  32'(imem_req),  32'h1);
    check("a_addr1", 32'(imem_addr), 32'h0);
    tick();
    check("a_valid", 32'(instr_valid), 32'h1);
    check("a_op",    32'({opcode, rd, rs1, rs2}), 32'h2123);
    check("a_pc",    32'(pc), 32'h1);
    tick();
    check("a_req3",  32'(imem_req),  32'h1);
    check("a_addr3", 32'(imem_addr), 32'h1);

    // Slow memory (3 wait cycles), downstream stalls 4 cycles.
    do_reset();
    mem[0] = 16'h3456; run = 1'b1; instr_ready = 1'b0; lat = 3;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b_req_held", 32'(imem_req), 32'h1);
    end
    run = 1'b0;
    x0 = xfers;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b_valid_held", 32'(instr_valid), 32'h1);
      check("b_fields",     32'({opcode, rd, rs1, rs2}), 32'h3456);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("b_valid_drop", 32'(instr_valid), 32'h0);
    tick();
    check("b_one_xfer", 32'(xfers - x0), 32'h1);
    check("b_idle_req", 32'(imem_req), 32'h0);

    // HALT at address 2, then jump to 0x10.
    do_reset();
    mem[0] = 16'h1111; mem[1] = 16'h4222; mem[2] = 16'hF000; mem[3] = 16'h5555;
    run = 1'b1; instr_ready = 1'b1; lat = 0;
    x0 = xfers;
    for (int i = 0; i < 10; i++) tick();
    check("c_halted", 32'(halted), 32'h1);
    check("c_pc",     32'(pc),     32'h3);
    check("c_xfers",  32'(xfers - x0), 32'h3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("c_no_req", 32'(imem_req), 32'h0);
    end
    pc_load = 1'b1; pc_load_val = 8'h10;
    tick();
    pc_load = 1'b0;
    check("c_resume_req",  32'(imem_req),  32'h1);
    check("c_resume_addr", 32'(imem_addr), 32'h10);
    check("c_unhalted",    32'(halted),    32'h0);

    // PC wrap from 0xFF.
    do_reset();
    mem[8'hFF] = 16'h2ABC;
    run = 1'b1; instr_ready = 1'b1; lat = 0;
    pc_load = 1'b1; pc_load_val = 8'hFF;
    tick();
    pc_load = 1'b0;
    check("d_addr_ff", 32'(imem_addr), 32'hFF);
    tick();
    check("d_pc_wrap", 32'(pc), 32'h0);
    check("d_op",      32'({opcode, rd, rs1, rs2}), 32'h2ABC);
    tick();
    check("d_req0",  32'(imem_req),  32'h1);
    check("d_addr0", 32'(imem_addr), 32'h0);

    // Jump in the same cycle as an ack: ack discarded.
    do_reset();
    mem[0] = 16'h7123; run = 1'b1; instr_ready = 1'b1; lat = 0;
    tick();
    tick();
    lat = 5;
    tick();
    ovr = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hABCD;
    pc_load = 1'b1; pc_load_val = 8'h40;
    tick();
    pc_load = 1'b0; imem_ack = 1'b0;
    check("e_no_valid", 32'(instr_valid), 32'h0);
    check("e_ir_kept",  32'({opcode, rd, rs1, rs2}), 32'h7123);
    check("e_addr",     32'(imem_addr), 32'h40);
    check("e_req",      32'(imem_req),  32'h1);

    // Reset while awaiting ack, late ack the cycle after.
    rst = 1'b1;
    tick();
    rst = 1'b0; run = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h9999;
    tick();
    imem_ack = 1'b0;
    check("f_req",    32'(imem_req),    32'h0);
    check("f_valid",  32'(instr_valid), 32'h0);
    check("f_pc",     32'(pc),          32'h0);
    check("f_fields", 32'({opcode, rd, rs1, rs2}), 32'h0);
    tick();
    check("f_fields2", 32'({opcode, rd, rs1, rs2}), 32'h0);
    check("f_valid2",  32'(instr_valid), 32'h0);
    ovr = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i][15:12] == 4'hF && $urandom_range(0, 2) != 0) mem[i][15:12] = 4'h0;
    end
    rnd_lat = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      pc_load     = ($urandom_range(0, 39) == 0);
      pc_load_val = 8'($urandom);
      run         = ($urandom_range(0, 7) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b0; pc_load = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the control unit. It holds the program counter and fetches 16-bit instructions from instruction memory over a req/ack handshake. It latches each instruction into an instruction register and presents the decoded fields (opcode to the control unit, register indices to the register file) with a valid/ready handshake. It also handles jumps (PC load) and a HALT opcode that stops fetching.

## Interface
Parameters:
- PC_W, 8, program counter / instruction address width
- HALT_OP, 4'b1111, opcode that stops fetching after issue

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- run  in  1  fetch enable; when low no new memory request is started
- pc_load  in  1  jump strobe; loads pc_load_val into the PC
- pc_load_val  in  PC_W  jump target
- imem_req  out  1  instruction memory read request
- imem_addr  out  PC_W  read address, equals the PC
- imem_ack  in  1  memory response valid; may assert in the same cycle as imem_req
- imem_rdata  in  16  instruction word, valid when imem_ack=1
- instr_valid  out  1  instruction register holds an unconsumed instruction
- instr_ready  in  1  downstream accepts the instruction
- opcode  out  4  IR[15:12], to the control unit
- rd  out  4  IR[11:8]
- rs1  out  4  IR[7:4]
- rs2  out  4  IR[3:0], second source or 4-bit immediate
- pc  out  PC_W  current PC, the address of the next fetch
- halted  out  1  high while in HALT

## Operation
- States:
  - IDLE: no request.
  - FETCH: imem_req=1.
  - HOLD: instr_valid=1, waiting for accept.
  - HALT: fetch stopped.
- Reset values: state IDLE, pc=0, IR=16'h0000 (opcode/rd/rs1/rs2=0), instr_valid=0, imem_req=0, imem_addr=0, halted=0.
- Outputs:
  - imem_req=1 exactly in FETCH.
  - imem_addr=pc always.
  - instr_valid=1 exactly in HOLD.
  - halted=1 exactly in HALT.
- Transitions:
  - IDLE -> FETCH when run=1.
  - FETCH -> HOLD on imem_ack=1: IR<=imem_rdata, pc<=pc+1. Without ack, stay in FETCH with imem_req held high. The request is never retracted, even if run drops.
  - HOLD with instr_ready=1 (the transfer):
    - if opcode==HALT_OP -> HALT;
    - else if run=1 -> FETCH;
    - else -> IDLE.
  - HOLD without instr_ready: IR and fields held stable.
  - HALT: stays until pc_load or rst.
- PC arithmetic: pc+1 is modulo 2^PC_W; address 2^PC_W-1 wraps to 0.
- pc_load=1 has priority over all other events in every state (rst excepted):
  - pc<=pc_load_val; next state FETCH if run=1, else IDLE.
  - In FETCH, an ack arriving in the same cycle is discarded: IR is not written and pc does not increment.
  - In HOLD, the held instruction is dropped (instr_valid falls) even if instr_ready=1 that cycle; it counts as not transferred.
  - In HALT, fetching resumes and halted clears.
- rst mid-operation, including FETCH awaiting ack: return to reset values next cycle; a late ack after reset is ignored in IDLE.
- The HALT instruction itself is delivered downstream (one transfer); nothing after it is fetched.

## Timing
- Zero-wait memory (ack in same cycle as req): req in cycle N, instr_valid in N+1. If instr_ready=1 in N+1, the next req is in N+2. Throughput is 1 instruction per 2 cycles.
- W-cycle memory wait: instr_valid rises 1 cycle after the ack cycle.
- opcode/rd/rs1/rs2 change only on the clock edge that writes IR. They are stable throughout HOLD.
- pc_load takes effect on the next edge: imem_addr=pc_load_val in the following cycle.
- run is sampled only in IDLE and at the HOLD transfer.

## Test plan
- Reset then run=1, zero-wait memory returning 16'h2123 at address 0, instr_ready=1:
  - imem_req in cycle 1;
  - instr_valid in cycle 2 with opcode=2, rd=1, rs1=2, rs2=3;
  - pc=1;
  - next req in cycle 3 at address 1.
- Memory ack delayed 3 cycles, instr_ready held low 4 cycles: imem_req stays high until the ack; instr_valid stays high with fields unchanged until instr_ready; exactly one transfer.
- Word 16'hF000 at address 2: after its transfer, halted=1 and imem_req=0 indefinitely. A pc_load to 0x10 then produces a req at 0x10 the next cycle and halted=0.
- PC_W=8, pc_load_val=8'hFF: fetch from 0xFF, then pc=0x00 and the next req is at address 0.
- pc_load asserted in the same cycle as imem_ack: IR unchanged, no instr_valid, next req at pc_load_val.
- rst asserted while in FETCH awaiting ack; ack arrives the cycle after: all outputs at reset values, IR stays 0, no instr_valid.
